// File: rtl/emperor_axi_lite_pkg.sv
// Shared AXI-Lite response codes and FSM state types for the register file.
package emperor_axi_lite_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

endpackage

// File: rtl/emperor_axi_lite_regfile.sv
// AXI4-Lite slave register file with read-only registers, byte strobes and per-register write pulses.
module emperor_axi_lite_regfile
   import emperor_axi_lite_pkg::*;
#(
   parameter int unsigned           ADDR_W    = 32,
   parameter int unsigned           DATA_W    = 32,
   parameter int unsigned           NUM_REGS  = 16,
   parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
   parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
   input  logic                         aclk,
   input  logic                         arst_n,
   input  logic [ADDR_W-1:0]            S_AXI_awaddr,
   input  logic [2:0]                   S_AXI_awprot,
   input  logic                         S_AXI_awvalid,
   output logic                         S_AXI_awready,
   input  logic [DATA_W-1:0]            S_AXI_wdata,
   input  logic [DATA_W/8-1:0]          S_AXI_wstrb,
   input  logic                         S_AXI_wvalid,
   output logic                         S_AXI_wready,
   output logic [1:0]                   S_AXI_bresp,
   output logic                         S_AXI_bvalid,
   input  logic                         S_AXI_bready,
   input  logic [ADDR_W-1:0]            S_AXI_araddr,
   input  logic [2:0]                   S_AXI_arprot,
   input  logic                         S_AXI_arvalid,
   output logic                         S_AXI_arready,
   output logic [DATA_W-1:0]            S_AXI_rdata,
   output logic [1:0]                   S_AXI_rresp,
   output logic                         S_AXI_rvalid,
   input  logic                         S_AXI_rready,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
   output logic [NUM_REGS-1:0]          wr_pulse
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFFS   = $clog2(STRB_W);

   w_state_e            w_state, w_state_nxt;
   r_state_e            r_state, r_state_nxt;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   w_data_q;
   logic [STRB_W-1:0]   w_strb_q;
   logic                aw_hs, w_hs, ar_hs;
   logic                commit;
   logic [ADDR_W-1:0]   cm_addr, cm_idx, ar_idx;
   logic [DATA_W-1:0]   cm_data, rdata_nxt;
   logic [STRB_W-1:0]   cm_strb;
   logic [NUM_REGS-1:0] cm_sel;
   logic [1:0]          bresp_nxt, rresp_nxt;
   logic                unused_ok;

   // Protection bits carry no meaning here; the RO data of writable slots is never returned.
   assign unused_ok = ^{S_AXI_awprot, S_AXI_arprot, ro_d};

   assign aw_hs = S_AXI_awvalid & S_AXI_awready;
   assign w_hs  = S_AXI_wvalid  & S_AXI_wready;
   assign ar_hs = S_AXI_arvalid & S_AXI_arready;

   // Write FSM next state, commit selection (live channel beats bypass the capture regs) and decode.
   always_comb begin
      w_state_nxt = w_state;
      commit      = 1'b0;
      cm_addr     = aw_addr_q;
      cm_data     = w_data_q;
      cm_strb     = w_strb_q;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit      = 1'b1;
               cm_addr     = S_AXI_awaddr;
               cm_data     = S_AXI_wdata;
               cm_strb     = S_AXI_wstrb;
               w_state_nxt = W_RESP;
            end else if (aw_hs) begin
               w_state_nxt = W_HAVE_AW;
            end else if (w_hs) begin
               w_state_nxt = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            if (w_hs) begin
               commit      = 1'b1;
               cm_data     = S_AXI_wdata;
               cm_strb     = S_AXI_wstrb;
               w_state_nxt = W_RESP;
            end
         end
         W_HAVE_W: begin
            if (aw_hs) begin
               commit      = 1'b1;
               cm_addr     = S_AXI_awaddr;
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (S_AXI_bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
      cm_idx = cm_addr >> OFFS;
      for (int i = 0; i < NUM_REGS; i++) begin
         cm_sel[i] = commit && (cm_idx == ADDR_W'(i)) && !RO_MASK[i];
      end
      bresp_nxt = S_AXI_bresp;
      if (commit) bresp_nxt = (|cm_sel) ? OKAY : SLVERR;
   end

   // Write FSM state and registered write-channel outputs.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         w_state       <= W_IDLE;
         S_AXI_awready <= 1'b0;
         S_AXI_wready  <= 1'b0;
         S_AXI_bvalid  <= 1'b0;
         S_AXI_bresp   <= OKAY;
         wr_pulse      <= '0;
      end else begin
         w_state       <= w_state_nxt;
         S_AXI_awready <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_W);
         S_AXI_wready  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_AW);
         S_AXI_bvalid  <= (w_state_nxt == W_RESP);
         S_AXI_bresp   <= bresp_nxt;
         wr_pulse      <= cm_sel;
      end
   end

   // Hold whichever of AW / W arrived first until its partner shows up.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) aw_addr_q <= S_AXI_awaddr;
         if (w_hs) begin
            w_data_q <= S_AXI_wdata;
            w_strb_q <= S_AXI_wstrb;
         end
      end
   end

   // Register storage with byte-strobe merge on commit.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cm_sel[i]) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (cm_strb[b]) regs[i][b*8 +: 8] <= cm_data[b*8 +: 8];
               end
            end
         end
      end
   end

   // Flatten storage onto the register-content bus.
   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_W +: DATA_W] = regs[i];
   end

   // Read FSM next state and read-data mux (samples storage before any same-edge write).
   always_comb begin
      r_state_nxt = r_state;
      rdata_nxt   = S_AXI_rdata;
      rresp_nxt   = S_AXI_rresp;
      ar_idx      = S_AXI_araddr >> OFFS;
      case (r_state)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_nxt = R_DATA;
               rdata_nxt   = '0;
               rresp_nxt   = SLVERR;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (ar_idx == ADDR_W'(i)) begin
                     rdata_nxt = RO_MASK[i] ? ro_d[i*DATA_W +: DATA_W] : regs[i];
                     rresp_nxt = OKAY;
                  end
               end
            end
         end
         R_DATA: begin
            if (S_AXI_rready) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   // Read FSM state and registered read-channel outputs.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         r_state       <= R_IDLE;
         S_AXI_arready <= 1'b0;
         S_AXI_rvalid  <= 1'b0;
         S_AXI_rdata   <= '0;
         S_AXI_rresp   <= OKAY;
      end else begin
         r_state       <= r_state_nxt;
         S_AXI_arready <= (r_state_nxt == R_IDLE);
         S_AXI_rvalid  <= (r_state_nxt == R_DATA);
         S_AXI_rdata   <= rdata_nxt;
         S_AXI_rresp   <= rresp_nxt;
      end
   end

endmodule

// File: tb/tb_emperor_axi_lite_regfile.sv
// Scoreboard bench for the AXI-Lite register file: randomized traffic against a word/byte array model.
module tb_emperor_axi_lite_regfile;

   localparam int unsigned    NR     = 16;
   localparam logic [15:0]    RO_SET = 16'h0208;
   localparam logic [31:0]    RV     = 32'h1111_1111;

   typedef struct packed { logic [1:0] resp; logic [15:0] pulse; } bexp_t;
   typedef struct packed { logic [31:0] data; logic [1:0] resp; } rexp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [31:0]   awaddr, wdata, araddr, rdata;
   logic [2:0]    awprot, arprot;
   logic [3:0]    wstrb;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [1:0]    bresp, rresp;
   logic [NR*32-1:0] reg_q, ro_d;
   logic [NR-1:0] wr_pulse;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [31:0]   model [NR];
   bexp_t         bq[$];
   rexp_t         rq[$];
   logic [15:0]   pulse_acc = '0;
   int            pulse_cnt = 0;

   emperor_axi_lite_regfile #(
      .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR), .RO_MASK(RO_SET), .RESET_VAL(RV)
   ) dut (
      .aclk(clk), .arst_n(rst_n),
      .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
      .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
      .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
      .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
      .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
      .reg_q(reg_q), .ro_d(ro_d), .wr_pulse(wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: handshake timeout (t=%0t)", name, $time);
   endtask

   function automatic rexp_t model_read(input logic [31:0] addr);
      rexp_t       e;
      logic [31:0] idx = addr >> 2;
      logic [15:0] m   = RO_SET;
      int          i;
      if (idx >= NR) begin
         e.data = '0;
         e.resp = 2'b10;
      end else begin
         i      = int'(idx);
         e.data = m[i] ? ro_d[i*32 +: 32] : model[i];
         e.resp = 2'b00;
      end
      return e;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output bexp_t e);
      logic [31:0] idx = addr >> 2;
      logic [15:0] m   = RO_SET;
      int          i;
      e.resp  = 2'b10;
      e.pulse = '0;
      if (idx < NR) begin
         i = int'(idx);
         if (!m[i]) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[i][b*8 +: 8] = data[b*8 +: 8];
            e.resp     = 2'b00;
            e.pulse[i] = 1'b1;
         end
      end
   endtask

   // Monitor: pops expectations whenever a B or R handshake is presented.
   always @(negedge clk) begin
      bexp_t be;
      rexp_t re;
      if (rst_n) begin
         pulse_cnt += $countones(wr_pulse);
         pulse_acc |= wr_pulse;
         if (bvalid && bready) begin
            if (bq.size() == 0) timeout("b_unexpected");
            else begin
               be = bq.pop_front();
               chk("bresp", 64'(bresp), 64'(be.resp));
               chk("wr_pulse_vec", 64'(pulse_acc), 64'(be.pulse));
               chk("wr_pulse_cnt", 64'(pulse_cnt), (be.pulse != 0) ? 64'd1 : 64'd0);
               pulse_acc = '0;
               pulse_cnt = 0;
            end
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) timeout("r_unexpected");
            else begin
               re = rq.pop_front();
               chk("rdata", 64'(rdata), 64'(re.data));
               chk("rresp", 64'(rresp), 64'(re.resp));
            end
         end
      end
   end

   // Address and data phases with independent start gaps; returns after the last beat is taken.
   task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input int aw_gap, input int w_gap);
      bexp_t e;
      bit    aw_done = 0, w_done = 0, aw_fire, w_fire;
      int    c = 0;
      model_write(addr, data, strb, e);
      bq.push_back(e);
      awaddr = addr; wdata = data; wstrb = strb;
      while (!(aw_done && w_done) && c < 60) begin
         awvalid = !aw_done && (c >= aw_gap);
         wvalid  = !w_done && (c >= w_gap);
         @(negedge clk);
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_fire) aw_done = 1;
         if (w_fire) w_done = 1;
         c++;
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) timeout("aw_w_accept");
   endtask

   task automatic finish_b(input int delay);
      bit done = 0, fire;
      int c = 0;
      while (!done && c < 60) begin
         bready = (c >= delay);
         @(negedge clk);
         fire = bvalid && bready;
         @(posedge clk); #1;
         if (fire) done = 1;
         c++;
      end
      bready = 0;
      if (!done) timeout("b_handshake");
   endtask

   task automatic issue_read(input logic [31:0] addr);
      bit done = 0, fire;
      int c = 0;
      rq.push_back(model_read(addr));
      araddr = addr;
      while (!done && c < 60) begin
         arvalid = 1;
         @(negedge clk);
         fire = arvalid && arready;
         @(posedge clk); #1;
         if (fire) done = 1;
         c++;
      end
      arvalid = 0;
      if (!done) timeout("ar_accept");
   endtask

   task automatic finish_r(input int delay);
      bit done = 0, fire;
      int c = 0;
      while (!done && c < 60) begin
         rready = (c >= delay);
         @(negedge clk);
         fire = rvalid && rready;
         @(posedge clk); #1;
         if (fire) done = 1;
         c++;
      end
      rready = 0;
      if (!done) timeout("r_handshake");
   endtask

   task automatic chk_all_regs(input string name);
      for (int i = 0; i < NR; i++) chk(name, 64'(reg_q[i*32 +: 32]), 64'(model[i]));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bexp_t       be;
      logic [31:0] a, d, old;
      rst_n = 0;
      awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
      araddr = 0; arprot = 0; arvalid = 0; rready = 0;
      for (int i = 0; i < NR; i++) begin
         model[i] = RV;
         ro_d[i*32 +: 32] = $urandom;
      end
      ro_d[3*32 +: 32] = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      chk("rst_awready", 64'(awready), 0);
      chk("rst_wready", 64'(wready), 0);
      chk("rst_arready", 64'(arready), 0);
      chk("rst_bvalid", 64'(bvalid), 0);
      chk("rst_rvalid", 64'(rvalid), 0);
      chk_all_regs("rst_reg_q");
      rst_n = 1;
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_awready", 64'(awready), 1);
      chk("post_rst_wready", 64'(wready), 1);
      chk("post_rst_arready", 64'(arready), 1);
      @(posedge clk); #1;

      // Same-cycle AW/W to reg 2
      issue_write(32'h08, 32'hA5A5_1234, 4'hF, 0, 0);
      finish_b(0);
      issue_read(32'h08);
      finish_r(0);
      chk("reg2_value", 64'(reg_q[2*32 +: 32]), 64'h0000_0000_A5A5_1234);

      // W three cycles ahead of AW, single byte lane
      issue_write(32'h04, 32'h0000_FF00, 4'h2, 3, 0);
      finish_b(1);
      issue_read(32'h04);
      finish_r(2);
      chk("reg1_merge", 64'(reg_q[1*32 +: 32]), 64'h0000_0000_1111_FF11);

      // Out-of-range write and read
      issue_write(32'h40, 32'h1234_5678, 4'hF, 0, 2);
      finish_b(0);
      issue_read(32'h40);
      finish_r(0);

      // Read-only register
      issue_write(32'h0C, 32'h0BAD_F00D, 4'hF, 1, 0);
      finish_b(0);
      issue_read(32'h0C);
      finish_r(0);

      // Stalled responses stay stable and block new requests
      issue_write(32'h14, 32'hCAFE_0014, 4'hF, 0, 1);
      issue_read(32'h08);
      repeat (5) begin
         @(negedge clk);
         chk("stall_bvalid", 64'(bvalid), 1);
         chk("stall_bresp", 64'(bresp), 0);
         chk("stall_rvalid", 64'(rvalid), 1);
         chk("stall_rdata", 64'(rdata), 64'h0000_0000_A5A5_1234);
         chk("stall_awready", 64'(awready), 0);
         chk("stall_wready", 64'(wready), 0);
         chk("stall_arready", 64'(arready), 0);
      end
      @(posedge clk); #1;
      finish_b(0);
      finish_r(0);

      // Read and write of reg 6 on the same edge: read sees the old contents
      old = model[6];
      rq.push_back(model_read(32'h18));
      model_write(32'h18, 32'h6666_0606, 4'hF, be);
      bq.push_back(be);
      awaddr = 32'h18; wdata = 32'h6666_0606; wstrb = 4'hF; araddr = 32'h18;
      awvalid = 1; wvalid = 1; arvalid = 1;
      @(negedge clk);
      chk("same_edge_readies", 64'({awready, wready, arready}), 64'h7);
      @(posedge clk); #1;
      awvalid = 0; wvalid = 0; arvalid = 0;
      finish_b(1);
      finish_r(0);
      chk("same_edge_old", 64'(old), 64'(RV));

      // Randomized traffic
      repeat (120) begin
         a = 32'($urandom_range(0, 19)) * 4 + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            issue_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            finish_b($urandom_range(0, 3));
         end else begin
            issue_read(a);
            finish_r($urandom_range(0, 3));
         end
      end
      chk_all_regs("rand_reg_q");

      // Reset while holding an address beat with no data
      awaddr = 32'h14; awvalid = 1;
      @(negedge clk);
      chk("rst_mid_aw_taken", 64'(awready), 1);
      @(posedge clk); #1;
      awvalid = 0;
      wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
      #2 rst_n = 0;
      #1;
      chk("arst_awready", 64'(awready), 0);
      chk("arst_wready", 64'(wready), 0);
      chk("arst_arready", 64'(arready), 0);
      chk("arst_bvalid", 64'(bvalid), 0);
      chk("arst_rvalid", 64'(rvalid), 0);
      chk("arst_bresp", 64'(bresp), 0);
      chk("arst_rresp", 64'(rresp), 0);
      chk("arst_rdata", 64'(rdata), 0);
      chk("arst_wr_pulse", 64'(wr_pulse), 0);
      chk("arst_reg5", 64'(reg_q[5*32 +: 32]), 64'(RV));
      for (int i = 0; i < NR; i++) model[i] = RV;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      chk_all_regs("after_arst_reg_q");
      issue_read(32'h14);
      finish_r(0);

      chk("bq_drained", 64'(bq.size()), 0);
      chk("rq_drained", 64'(rq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/emperor_axi_lite_regfile.md
EMPEROR_AXI_LITE_REGFILE -- requirements
Module: emperor_axi_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width; only 32 or 64 are legal.
REQ-003 SHALL have parameter NUM_REGS, default 16: register count, range 1..256.
REQ-004 SHALL have parameter RO_MASK, default '0 (NUM_REGS bits): a set bit makes that register read-only.
REQ-005 SHALL have parameter RESET_VAL, default '0 (DATA_W bits): reset value of every RW register.
REQ-006 SHALL have port aclk, input, 1 bit: single clock; all logic is rising-edge.
REQ-007 SHALL have port arst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have AW channel ports: S_AXI_awaddr (in, ADDR_W), S_AXI_awprot (in, 3), S_AXI_awvalid (in, 1), S_AXI_awready (out, 1).
REQ-009 SHALL have W channel ports: S_AXI_wdata (in, DATA_W), S_AXI_wstrb (in, DATA_W/8), S_AXI_wvalid (in, 1), S_AXI_wready (out, 1).
REQ-010 SHALL have B channel ports: S_AXI_bresp (out, 2), S_AXI_bvalid (out, 1), S_AXI_bready (in, 1).
REQ-011 SHALL have AR/R channel ports: S_AXI_araddr (in, ADDR_W), S_AXI_arprot (in, 3), S_AXI_arvalid (in, 1), S_AXI_arready (out, 1), S_AXI_rdata (out, DATA_W), S_AXI_rresp (out, 2), S_AXI_rvalid (out, 1), S_AXI_rready (in, 1).
REQ-012 SHALL have port reg_q, output, NUM_REGS*DATA_W: flat register contents; register i occupies bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port ro_d, input, NUM_REGS*DATA_W: values returned when a read-only register is read.
REQ-014 SHALL have port wr_pulse, output, NUM_REGS: one-cycle strobe per register on each successful write.

Function
REQ-015 Register index SHALL be addr >> log2(DATA_W/8); address bits below the word offset are ignored.
REQ-016 The write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP; AW and W are accepted independently, in either order or in the same cycle.
REQ-017 S_AXI_awready SHALL be high in W_IDLE and W_HAVE_W only; S_AXI_wready SHALL be high in W_IDLE and W_HAVE_AW only.
REQ-018 Once both AW and W are captured, the write SHALL commit on the next edge with per-byte wstrb masking; the FSM then enters W_RESP with bvalid=1.
REQ-019 bvalid and bresp SHALL hold until bready; on that handshake the FSM returns to W_IDLE, so a new AW/W can be accepted no earlier than the following cycle.
REQ-020 An out-of-range index (>= NUM_REGS) or a write to an RO_MASK register SHALL be discarded, give bresp=SLVERR (2'b10) and produce no wr_pulse.
REQ-021 A successful write SHALL give bresp=OKAY (2'b00) and assert wr_pulse[idx] for exactly the commit cycle.
REQ-022 The read path SHALL have states R_IDLE and R_DATA; arready=1 only in R_IDLE.
REQ-023 On an AR handshake, rdata and rresp SHALL be registered and rvalid=1 the next cycle, held stable until rready.
REQ-024 Reads SHALL return reg_q for RW registers and ro_d for RO registers; out-of-range reads SHALL return rdata=0 with rresp=SLVERR.
REQ-025 A read and a write to the same register committing in the same cycle SHALL return the pre-write value.
REQ-026 awprot and arprot SHALL be ignored.

Reset
REQ-027 While arst_n=0, and asynchronously on its assertion: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0, wr_pulse=0, RW registers=RESET_VAL, and both FSMs in their IDLE state.
REQ-028 Ready outputs SHALL rise on the first aclk edge after arst_n deasserts; an assertion mid-transaction SHALL abandon the transaction with no partial write.

Structure
REQ-029 Package emperor_axi_lite_pkg SHALL hold the resp constants (OKAY=2'b00, SLVERR=2'b10) and the write/read state enum typedefs.
REQ-030 The module SHALL be a single module with no sub-modules; read and write FSMs are separate always blocks.

Verification
REQ-031 Directed test: AW and W in the same cycle to addr 0x08, data 0xA5A5_1234, wstrb 0xF -> bresp=OKAY, wr_pulse[2] pulses once, reg 2 reads back 0xA5A5_1234.
REQ-032 Directed test: W issued 3 cycles before AW, addr 0x04, wstrb 0x2, data 0x0000_FF00 over 0x1111_1111 -> reg 1 = 0x1111_FF11.
REQ-033 Directed test: write to addr 0x40 with NUM_REGS=16 -> bresp=SLVERR, no wr_pulse; read of 0x40 -> rdata=0, rresp=SLVERR.
REQ-034 Directed test: RO_MASK bit 3 set, ro_d reg 3 = 0xDEAD_BEEF, write reg 3 -> SLVERR; read reg 3 -> 0xDEAD_BEEF.
REQ-035 Directed test: hold bready=0 and rready=0 for 5 cycles -> bvalid/bresp and rvalid/rdata stay stable, and awready/wready/arready stay 0.
REQ-036 Directed test: assert arst_n low while in W_HAVE_AW -> all outputs go to reset values asynchronously and the target register keeps RESET_VAL.
